// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and the iterative-op decode for seq_alu.
// SEQ_ALU_DIV_EN adds the DIV/REM opcodes to the iterative set.
package seq_alu_pkg;

  localparam logic [3:0] ALU_CONTROL_CONSTANT_ADD = 4'd0;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_SUB = 4'd1;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_AND = 4'd2;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_XOR = 4'd3;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_SLL = 4'd4;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_SRA = 4'd5;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_MUL = 4'd6;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_DIV = 4'd7;
  localparam logic [3:0] ALU_CONTROL_CONSTANT_REM = 4'd8;

  typedef enum logic [1:0] {
    SEQ_ALU_S_IDLE = 2'd0,
    SEQ_ALU_S_BUSY = 2'd1,
    SEQ_ALU_S_DONE = 2'd2
  } seq_alu_state_e;

  function automatic logic is_iter_op(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == ALU_CONTROL_CONSTANT_MUL) ||
           (op == ALU_CONTROL_CONSTANT_DIV) ||
           (op == ALU_CONTROL_CONSTANT_REM);
`else
    return (op == ALU_CONTROL_CONSTANT_MUL);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_iter_unit.sv
// Iterative datapath: shift-add MUL and, with SEQ_ALU_DIV_EN, signed restoring DIV/REM.
// One step per cycle; done_o pulses on the last step with res_o valid alongside it.
import seq_alu_pkg::*;

module alu_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

`ifdef SEQ_ALU_DIV_EN
  logic           div_q, div_d;
  logic           rem_q, rem_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic           div0_q, div0_d;
  logic [WIDTH:0] rs;
  logic           qbit;
`else
  logic unused_op;
  assign unused_op = ^op_i;
`endif

  // Capture on start, then one multiply or divide step per cycle.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    done_o = 1'b0;
    res_o  = '0;
`ifdef SEQ_ALU_DIV_EN
    div_d  = div_q;
    rem_d  = rem_q;
    negq_d = negq_q;
    negr_d = negr_q;
    div0_d = div0_q;
    rs     = '0;
    qbit   = 1'b0;
`endif
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = '0;
      x_d    = a_i;
      y_d    = b_i;
`ifdef SEQ_ALU_DIV_EN
      div_d  = (op_i == ALU_CONTROL_CONSTANT_DIV) ||
               (op_i == ALU_CONTROL_CONSTANT_REM);
      rem_d  = (op_i == ALU_CONTROL_CONSTANT_REM);
      negq_d = a_i[WIDTH-1] ^ b_i[WIDTH-1];
      negr_d = a_i[WIDTH-1];
      div0_d = (b_i == '0);
      if (div_d) begin
        x_d = a_i[WIDTH-1] ? -a_i : a_i;
        y_d = b_i[WIDTH-1] ? -b_i : b_i;
      end
`endif
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_d = 1'b0;
        done_o = 1'b1;
      end
`ifdef SEQ_ALU_DIV_EN
      if (div_q) begin
        rs = {acc_q, x_q[WIDTH-1]};
        if (rs >= {1'b0, y_q}) begin
          qbit = 1'b1;
          rs   = rs - {1'b0, y_q};
        end
        acc_d = rs[WIDTH-1:0];
        x_d   = {x_q[WIDTH-2:0], qbit};
      end else
`endif
      begin
        if (y_q[0]) acc_d = acc_q + x_q;
        x_d = x_q << 1;
        y_d = y_q >> 1;
      end
    end
`ifdef SEQ_ALU_DIV_EN
    if (!div_q)      res_o = acc_d;
    else if (rem_q)  res_o = negr_q ? -acc_d : acc_d;
    else if (div0_q) res_o = '1;
    else             res_o = negq_q ? -x_d : x_d;
`else
    res_o = acc_d;
`endif
  end

  // Iteration registers; reset drops any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
`ifdef SEQ_ALU_DIV_EN
      div_q  <= div_d;
      rem_q  <= rem_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
`endif
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle EX-stage ALU: valid/ready handshake, registered result and Zero flag.
// SEQ_ALU_DIV_EN enables DIV/REM in the iterative unit; otherwise they decode as unknown.
import seq_alu_pkg::*;

module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o
);

  localparam int SHW = $clog2(WIDTH);

  seq_alu_state_e   state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] it_res;
  logic             it_done;
  logic             accept;
  logic             it_start;
  logic [SHW-1:0]   shamt;

  assign shamt    = data2_i[SHW-1:0];
  assign ready_o  = (state_q == SEQ_ALU_S_IDLE) ||
                    ((state_q == SEQ_ALU_S_DONE) && ready_i);
  assign accept   = valid_i && ready_o;
  assign it_start = accept && is_iter_op(ALUCtrl_i);
  assign valid_o  = (state_q == SEQ_ALU_S_DONE);
  assign data_o   = data_q;
  assign Zero_o   = zero_q;

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (it_start),
    .op_i    (ALUCtrl_i),
    .a_i     (data1_i),
    .b_i     (data2_i),
    .done_o  (it_done),
    .res_o   (it_res)
  );

  // Single-cycle ops straight from the request operands.
  always_comb begin
    single_res = '0;
    case (ALUCtrl_i)
      ALU_CONTROL_CONSTANT_ADD: single_res = data1_i + data2_i;
      ALU_CONTROL_CONSTANT_SUB: single_res = data1_i - data2_i;
      ALU_CONTROL_CONSTANT_AND: single_res = data1_i & data2_i;
      ALU_CONTROL_CONSTANT_XOR: single_res = data1_i ^ data2_i;
      ALU_CONTROL_CONSTANT_SLL: single_res = data1_i << shamt;
      ALU_CONTROL_CONSTANT_SRA: single_res = $signed(data1_i) >>> shamt;
      default:                  single_res = '0;
    endcase
  end

  // Next state and result register load.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    zero_d  = zero_q;
    case (state_q)
      SEQ_ALU_S_BUSY: begin
        if (it_done) begin
          state_d = SEQ_ALU_S_DONE;
          data_d  = it_res;
          zero_d  = (it_res == '0);
        end
      end
      SEQ_ALU_S_IDLE, SEQ_ALU_S_DONE: begin
        if (state_q == SEQ_ALU_S_DONE && ready_i) state_d = SEQ_ALU_S_IDLE;
        if (accept) begin
          if (is_iter_op(ALUCtrl_i)) begin
            state_d = SEQ_ALU_S_BUSY;
          end else begin
            state_d = SEQ_ALU_S_DONE;
            data_d  = single_res;
            zero_d  = (single_res == '0);
          end
        end
      end
      default: state_d = SEQ_ALU_S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= SEQ_ALU_S_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed table, corner sequences, random vs model.
// Expectations for DIV/REM follow SEQ_ALU_DIV_EN.
import seq_alu_pkg::*;

module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, ready_o, valid_o, ready_i, zero;
  logic [3:0]  op;
  logic [31:0] d1, d2, dout;

  logic        valid8, ready8_o, vout8, ready8_i, zero8;
  logic [7:0]  a8, b8, dout8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(op), .data1_i(d1), .data2_i(d2), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(dout), .Zero_o(zero)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid8), .ready_o(ready8_o),
    .ALUCtrl_i(ALU_CONTROL_CONSTANT_MUL), .data1_i(a8), .data2_i(b8),
    .valid_o(vout8), .ready_i(ready8_i), .data_o(dout8), .Zero_o(zero8)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic iter_op(input logic [3:0] o);
`ifdef SEQ_ALU_DIV_EN
    return o == ALU_CONTROL_CONSTANT_MUL || o == ALU_CONTROL_CONSTANT_DIV ||
           o == ALU_CONTROL_CONSTANT_REM;
`else
    return o == ALU_CONTROL_CONSTANT_MUL;
`endif
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (o)
      ALU_CONTROL_CONSTANT_ADD: return a + b;
      ALU_CONTROL_CONSTANT_SUB: return a - b;
      ALU_CONTROL_CONSTANT_AND: return a & b;
      ALU_CONTROL_CONSTANT_XOR: return a ^ b;
      ALU_CONTROL_CONSTANT_SLL: return a << b[4:0];
      ALU_CONTROL_CONSTANT_SRA: return sa >>> b[4:0];
      ALU_CONTROL_CONSTANT_MUL: return a * b;
`ifdef SEQ_ALU_DIV_EN
      ALU_CONTROL_CONSTANT_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      ALU_CONTROL_CONSTANT_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return sa % sb;
      end
`endif
      default: return 0;
    endcase
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] r,
                       output logic z, output int lat);
    op = o; d1 = a; d2 = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    op = 4'($urandom); d1 = $urandom; d2 = $urandom;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = dout; z = zero;
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic        z;
    int          lat;
    logic [3:0]  ro;
    logic [31:0] ra, rb, e;

    tbl[0]  = '{ALU_CONTROL_CONSTANT_ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1};
    tbl[1]  = '{ALU_CONTROL_CONSTANT_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1};
    tbl[2]  = '{ALU_CONTROL_CONSTANT_AND, 32'hF0F0_1234, 32'h0FF0_FF00,
                32'h00F0_1200, 1'b0, 1};
    tbl[3]  = '{ALU_CONTROL_CONSTANT_XOR, 32'hAAAA_5555, 32'hFFFF_0000,
                32'h5555_5555, 1'b0, 1};
    tbl[4]  = '{ALU_CONTROL_CONSTANT_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1};
    tbl[5]  = '{ALU_CONTROL_CONSTANT_SRA, 32'h8000_0000, 32'hFFFF_FFE4,
                32'hF800_0000, 1'b0, 1};
    tbl[6]  = '{ALU_CONTROL_CONSTANT_MUL, 32'd7, 32'd6, 32'd42, 1'b0, 33};
    tbl[7]  = '{ALU_CONTROL_CONSTANT_MUL, 32'hFFFF_FFFF, 32'd3,
                32'hFFFF_FFFD, 1'b0, 33};
    tbl[8]  = '{4'd15, 32'd9, 32'd9, 32'd0, 1'b1, 1};
`ifdef SEQ_ALU_DIV_EN
    tbl[9]  = '{ALU_CONTROL_CONSTANT_DIV, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 1'b0, 33};
    tbl[10] = '{ALU_CONTROL_CONSTANT_REM, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFF, 1'b0, 33};
    tbl[11] = '{ALU_CONTROL_CONSTANT_DIV, 32'd5, 32'd0,
                32'hFFFF_FFFF, 1'b0, 33};
    tbl[12] = '{ALU_CONTROL_CONSTANT_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 1'b0, 33};
`else
    tbl[9]  = '{ALU_CONTROL_CONSTANT_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 1};
    tbl[10] = '{ALU_CONTROL_CONSTANT_REM, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b1, 1};
    tbl[11] = '{ALU_CONTROL_CONSTANT_DIV, 32'd5, 32'd0, 32'd0, 1'b1, 1};
    tbl[12] = '{ALU_CONTROL_CONSTANT_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                32'd0, 1'b1, 1};
`endif

    rst = 1'b1;
    valid_i = 0; ready_i = 0; op = 0; d1 = 0; d2 = 0;
    valid8 = 0; ready8_i = 0; a8 = 0; b8 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_data", dout, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_ready", 32'(ready_o), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, r, z, lat);
      chk($sformatf("tbl%0d_data", i), r, tbl[i].res);
      chk($sformatf("tbl%0d_zero", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
    end

    // back-to-back single-cycle ops with the consumer always ready
    ready_i = 1'b1;
    op = ALU_CONTROL_CONSTANT_ADD; d1 = 32'h7FFF_FFFF; d2 = 32'd1;
    valid_i = 1'b1;
    @(posedge clk); #1;
    chk("b2b_add_valid", 32'(valid_o), 32'd1);
    chk("b2b_add_data", dout, 32'h8000_0000);
    chk("b2b_add_zero", 32'(zero), 32'd0);
    chk("b2b_ready", 32'(ready_o), 32'd1);
    op = ALU_CONTROL_CONSTANT_SUB; d1 = 32'd5; d2 = 32'd5;
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("b2b_sub_valid", 32'(valid_o), 32'd1);
    chk("b2b_sub_data", dout, 32'd0);
    chk("b2b_sub_zero", 32'(zero), 32'd1);
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("b2b_idle", 32'(valid_o), 32'd0);

    // MUL result held while the consumer stalls
    op = ALU_CONTROL_CONSTANT_MUL; d1 = 32'd7; d2 = 32'd6; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; d1 = 32'd100; d2 = 32'd100;
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("hold_lat", 32'(lat), 32'd33);
    for (int k = 0; k < 4; k++) begin
      chk("hold_data", dout, 32'd42);
      chk("hold_ready", 32'(ready_o), 32'd0);
      chk("hold_valid", 32'(valid_o), 32'd1);
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    #1;
    chk("hold_release_ready", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("hold_release_valid", 32'(valid_o), 32'd0);

    // asynchronous reset in the middle of a MUL
    op = ALU_CONTROL_CONSTANT_MUL; d1 = 32'd3; d2 = 32'd5; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_data", dout, 32'd0);
    chk("arst_ready", 32'(ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(ALU_CONTROL_CONSTANT_ADD, 32'd2, 32'd3, r, z, lat);
    chk("arst_next_data", r, 32'd5);
    chk("arst_next_lat", 32'(lat), 32'd1);
    do_op(ALU_CONTROL_CONSTANT_MUL, 32'd3, 32'd5, r, z, lat);
    chk("arst_mul_data", r, 32'd15);
    chk("arst_mul_lat", 32'(lat), 32'd33);

    // 8-bit instance: MUL overflow wraps to zero
    a8 = 8'h10; b8 = 8'h10; valid8 = 1'b1;
    @(posedge clk); #1;
    valid8 = 1'b0;
    lat = 1;
    while (!vout8 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_lat", 32'(lat), 32'd9);
    chk("w8_data", 32'(dout8), 32'd0);
    chk("w8_zero", 32'(zero8), 32'd1);
    ready8_i = 1'b1;
    @(posedge clk); #1;
    ready8_i = 1'b0;

    // random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      ro = 4'($urandom_range(0, 9));
      if (ro == 4'd9) ro = 4'd15;
      ra = $urandom;
      rb = (n % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      e = model(ro, ra, rb);
      do_op(ro, ra, rb, r, z, lat);
      chk($sformatf("rnd%0d_op%0d_data", n, ro), r, e);
      chk($sformatf("rnd%0d_zero", n), 32'(z), 32'(e == 0));
      chk($sformatf("rnd%0d_lat", n), 32'(lat),
          iter_op(ro) ? 32'd33 : 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
